// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared register-file widths, write-enable encoding and the write-back queue
// entry type used by wb_arbiter and its queue, wbq_fifo.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int          RegAddrBus  = 5;
    localparam int          RegBus      = 32;
    localparam int          Regnumlog2  = 5;
    localparam logic        WriteEnable = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    // Project default depth for the long-latency write-back queue
    localparam int          WbqDepth    = 4;

    typedef logic [RegAddrBus-1:0] reg_addr_t;
    typedef logic [RegBus-1:0]     reg_data_t;

    // One queued long-latency result; 'valid' drops when a younger pipe
    // write to the same register makes this result dead.
    typedef struct packed {
        logic      valid;
        reg_addr_t waddr;
        reg_data_t wdata;
    } wbq_entry_t;

    // True when a live entry will still write register 'addr'. r0 never
    // counts, since writes to it are discarded.
    function automatic logic addr_hit(input wbq_entry_t e, input reg_addr_t addr);
        return e.valid && (addr != '0) && (e.waddr == addr);
    endfunction

endpackage

// File: rtl/wbq_fifo.sv
// -----------------------------------------------------------------------------
// wbq_fifo
// Valid-tagged FIFO holding long-latency results waiting for the register
// file write port. A kill clears the valid bit of every entry writing a given
// register; killed entries keep their slot and drain as no-ops.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   push, push_waddr/wdata      enqueue a live entry (ignored when full)
//   pop                         dequeue the head (ignored when empty)
//   kill, kill_addr             invalidate all entries writing kill_addr
//   raddr1, raddr2              lookup addresses
//   match1, match2              a live entry writes raddr1 / raddr2
//   head                        entry at the read pointer
//   full, empty                 occupancy flags
// -----------------------------------------------------------------------------
module wbq_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WbqDepth
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [RegAddrBus-1:0] push_waddr,
    input  logic [RegBus-1:0]     push_wdata,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [RegAddrBus-1:0] kill_addr,
    input  logic [RegAddrBus-1:0] raddr1,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic                  match1,
    output logic                  match2,
    output wbq_entry_t            head,
    output logic                  full,
    output logic                  empty
);

    localparam int PtrW = $clog2(DEPTH);

    wbq_entry_t      mem [DEPTH];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [PtrW:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PtrW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two. A slot is
    // never pushed and popped in the same cycle: that would need the queue
    // to be both empty and full. Popped slots lose their valid bit so that
    // valid alone marks a live, occupied entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].waddr == kill_addr) begin
                        mem[i].valid <= 1'b0;
                    end
                end
            end
            if (do_pop) begin
                mem[rptr].valid <= 1'b0;
                rptr            <= rptr + PtrW'(1);
            end
            if (do_push) begin
                mem[wptr] <= '{valid: 1'b1, waddr: push_waddr, wdata: push_wdata};
                wptr      <= wptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PtrW+1)'(1);
                2'b01:   count <= count - (PtrW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Address lookups look only at registered entries, never at data being
    // pushed this cycle.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match1 = match1 | addr_hit(mem[i], raddr1);
            match2 = match2 | addr_hit(mem[i], raddr2);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Shares the register file's single write port between the MEM/WB pipeline
// result and a long-latency unit. The pipeline always wins; long-latency
// results queue in wbq_fifo and drain on cycles without a pipe write. Also
// reports queued writes to decode for read-after-write stalls.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pipe_we/pipe_waddr/pipe_wdata    pipeline write request (always taken)
//   lu_valid/lu_waddr/lu_wdata       long-latency result
//   lu_ready                         queue can accept this cycle
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   raddr1/raddr2                    decode read addresses
//   hazard1/hazard2                  a queued write targets raddr1/raddr2
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WbqDepth
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [RegAddrBus-1:0] pipe_waddr,
    input  logic [RegBus-1:0]     pipe_wdata,
    input  logic                  lu_valid,
    input  logic [RegAddrBus-1:0] lu_waddr,
    input  logic [RegBus-1:0]     lu_wdata,
    output logic                  lu_ready,
    output logic                  rf_we,
    output logic [RegAddrBus-1:0] rf_waddr,
    output logic [RegBus-1:0]     rf_wdata,
    input  logic [RegAddrBus-1:0] raddr1,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic                  hazard1,
    output logic                  hazard2
);

    logic       pipe_commit;
    logic       lu_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       match1;
    logic       match2;
    wbq_entry_t head;

    // A pipe write to r0 is no write at all, so it leaves the port free for
    // the queue. An accepted lu result is dropped rather than queued when it
    // targets r0 or is overwritten by the younger pipe result this cycle.
    assign pipe_commit = pipe_we && (pipe_waddr != '0);
    assign lu_ready    = !fifo_full && !rst;
    assign lu_push     = lu_valid && lu_ready && (lu_waddr != '0)
                         && !(pipe_commit && (lu_waddr == pipe_waddr));
    assign fifo_pop    = !pipe_commit && !fifo_empty;

    assign hazard1 = match1 && !rst;
    assign hazard2 = match2 && !rst;

    wbq_fifo #(
        .DEPTH (DEPTH)
    ) u_wbq (
        .clk        (clk),
        .rst        (rst),
        .push       (lu_push),
        .push_waddr (lu_waddr),
        .push_wdata (lu_wdata),
        .pop        (fifo_pop),
        .kill       (pipe_commit),
        .kill_addr  (pipe_waddr),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .match1     (match1),
        .match2     (match2),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // A popped killed entry still costs the port a cycle: it is presented
    // with its own address and data but with the write enable low. With
    // nothing to write, address and data hold their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= WriteDisable;
            rf_waddr <= '0;
            rf_wdata <= ZeroWord;
        end else if (pipe_commit) begin
            rf_we    <= WriteEnable;
            rf_waddr <= pipe_waddr;
            rf_wdata <= pipe_wdata;
        end else if (fifo_pop) begin
            rf_we    <= head.valid;
            rf_waddr <= head.waddr;
            rf_wdata <= head.wdata;
        end else begin
            rf_we    <= WriteDisable;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter. A queue-based reference model tracks
// pending long-latency writes and the expected register-file port.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        hazard1;
    logic        hazard2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lu_valid   (lu_valid),
        .lu_waddr   (lu_waddr),
        .lu_wdata   (lu_wdata),
        .lu_ready   (lu_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .hazard1    (hazard1),
        .hazard2    (hazard2)
    );

    // Reference model: pending long-latency writes, oldest first, each with
    // a live flag, plus the expected register-file port.
    typedef struct {
        bit          live;
        logic [4:0]  addr;
        logic [31:0] data;
    } pend_t;

    pend_t       pend[$];
    logic        exp_we    = 1'b0;
    logic [4:0]  exp_waddr = '0;
    logic [31:0] exp_wdata = '0;

    function automatic logic model_ready();
        return !rst && (pend.size() < DEPTH);
    endfunction

    function automatic logic model_hazard(input logic [4:0] a);
        if (rst || a == 5'd0) return 1'b0;
        foreach (pend[i]) begin
            if (pend[i].live && pend[i].addr == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Apply one clock edge of arbitration rules to the model.
    task automatic model_update();
        bit    commit;
        bit    accept;
        pend_t e;
        if (rst) begin
            pend.delete();
            exp_we    = 1'b0;
            exp_waddr = '0;
            exp_wdata = '0;
            return;
        end
        commit = pipe_we && (pipe_waddr != 5'd0);
        accept = lu_valid && (pend.size() < DEPTH);
        if (commit) begin
            exp_we    = 1'b1;
            exp_waddr = pipe_waddr;
            exp_wdata = pipe_wdata;
            foreach (pend[i]) begin
                if (pend[i].addr == pipe_waddr) pend[i].live = 1'b0;
            end
        end else if (pend.size() > 0) begin
            e         = pend.pop_front();
            exp_we    = e.live;
            exp_waddr = e.addr;
            exp_wdata = e.data;
        end else begin
            exp_we = 1'b0;
        end
        if (accept && lu_waddr != 5'd0 && !(commit && lu_waddr == pipe_waddr)) begin
            e.live = 1'b1;
            e.addr = lu_waddr;
            e.data = lu_wdata;
            pend.push_back(e);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we    = 1'b0;
        pipe_waddr = '0;
        pipe_wdata = '0;
        lu_valid   = 1'b0;
        lu_waddr   = '0;
        lu_wdata   = '0;
        raddr1     = '0;
        raddr2     = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cycle();
        cycle();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_rf: got we=%b a=%0d d=%h, want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        vectors++;
        if ({lu_ready, hazard1, hazard2} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got ready=%b h1=%b h2=%b, want 000", lu_ready, hazard1, hazard2);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (lu_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: got %b want 1", lu_ready);
        end
    endtask

    task automatic test_pipe_write();
        idle_inputs();
        pipe_we    = 1'b1;
        pipe_waddr = 5'd5;
        pipe_wdata = 32'h1234;
        cycle();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}
            || {rf_we, rf_waddr, rf_wdata} !== {exp_we, exp_waddr, exp_wdata}) begin
            miscompares++;
            $display("[TB] FAIL pipe_write: got we=%b a=%0d d=%h want 1/5/1234", rf_we, rf_waddr, rf_wdata);
        end
        pipe_waddr = 5'd0;
        pipe_wdata = 32'hBEEF;
        cycle();
        vectors++;
        if (rf_we !== 1'b0 || {rf_we, rf_waddr, rf_wdata} !== {exp_we, exp_waddr, exp_wdata}) begin
            miscompares++;
            $display("[TB] FAIL pipe_r0: got we=%b a=%0d d=%h want we=0 a=%0d d=%h",
                     rf_we, rf_waddr, rf_wdata, exp_waddr, exp_wdata);
        end
        idle_inputs();
    endtask

    task automatic test_fill_drain();
        idle_inputs();
        repeat (DEPTH + 2) cycle();
        // A lone accept reaches the port two cycles later
        lu_valid = 1'b1;
        lu_waddr = 5'd1;
        lu_wdata = 32'hC1;
        cycle();
        lu_valid = 1'b0;
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lone_lat1: got we=%b want 0", rf_we);
        end
        cycle();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'hC1}) begin
            miscompares++;
            $display("[TB] FAIL lone_lat2: got we=%b a=%0d d=%h want 1/1/c1", rf_we, rf_waddr, rf_wdata);
        end
        // Fill to capacity while the pipe holds the port
        for (int i = 1; i <= 4; i++) begin
            pipe_we    = 1'b1;
            pipe_waddr = 5'd20;
            pipe_wdata = 32'h2000 + 32'(i);
            lu_valid   = 1'b1;
            lu_waddr   = 5'(i);
            lu_wdata   = 32'hD0 + 32'(i);
            #1;
            vectors++;
            if (lu_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL fill_ready %0d: got %b want 1", i, lu_ready);
            end
            cycle();
            vectors++;
            if ({rf_we, rf_waddr} !== {1'b1, 5'd20}) begin
                miscompares++;
                $display("[TB] FAIL fill_pipe %0d: got we=%b a=%0d want 1/20", i, rf_we, rf_waddr);
            end
        end
        // Full queue refuses even though it pops this cycle
        pipe_we  = 1'b0;
        lu_valid = 1'b1;
        lu_waddr = 5'd5;
        lu_wdata = 32'hD5;
        #1;
        vectors++;
        if (lu_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_ready: got %b want 0", lu_ready);
        end
        for (int i = 1; i <= 5; i++) begin
            cycle();
            lu_valid = 1'b0;
            vectors++;
            if (rf_we !== 1'(i <= 4) || (i <= 4 && (rf_waddr !== 5'(i) || rf_wdata !== 32'hD0 + 32'(i)))) begin
                miscompares++;
                $display("[TB] FAIL drain %0d: got we=%b a=%0d d=%h want we=%b a=%0d",
                         i, rf_we, rf_waddr, rf_wdata, (i <= 4), i);
            end
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        repeat (DEPTH + 2) cycle();
        lu_valid = 1'b1;
        lu_waddr = 5'd7;
        lu_wdata = 32'hAA;
        cycle();
        lu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pipe_we    = 1'b1;
            pipe_waddr = 5'd9;
            pipe_wdata = 32'h900 + 32'(k);
            cycle();
            vectors++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h900 + 32'(k)}) begin
                miscompares++;
                $display("[TB] FAIL prio_pipe %0d: got we=%b a=%0d d=%h want 1/9/%h",
                         k, rf_we, rf_waddr, rf_wdata, 32'h900 + 32'(k));
            end
        end
        pipe_we = 1'b0;
        cycle();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hAA}) begin
            miscompares++;
            $display("[TB] FAIL prio_drain: got we=%b a=%0d d=%h want 1/7/aa", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_kill();
        idle_inputs();
        repeat (DEPTH + 2) cycle();
        raddr1   = 5'd3;
        lu_valid = 1'b1;
        lu_waddr = 5'd3;
        lu_wdata = 32'h11;
        cycle();
        lu_valid   = 1'b0;
        pipe_we    = 1'b1;
        pipe_waddr = 5'd3;
        pipe_wdata = 32'h22;
        #1;
        vectors++;
        if (hazard1 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL kill_hazard_before: got %b want 1", hazard1);
        end
        cycle();
        pipe_we = 1'b0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h22} || hazard1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL kill_commit: got we=%b a=%0d d=%h h1=%b want 1/3/22 h1=0",
                     rf_we, rf_waddr, rf_wdata, hazard1);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            vectors++;
            if (rf_we !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL kill_noop %0d: got we=%b a=%0d d=%h want we=0", k, rf_we, rf_waddr, rf_wdata);
            end
        end
    endtask

    task automatic test_hazard();
        idle_inputs();
        repeat (DEPTH + 2) cycle();
        raddr1   = 5'd6;
        raddr2   = 5'd0;
        lu_valid = 1'b1;
        lu_waddr = 5'd6;
        lu_wdata = 32'h66;
        #1;
        vectors++;
        if (hazard1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL haz_same_cycle: got %b want 0", hazard1);
        end
        pipe_we    = 1'b1;
        pipe_waddr = 5'd9;
        pipe_wdata = 32'h99;
        cycle();
        lu_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({hazard1, hazard2} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL haz_held %0d: got h1=%b h2=%b want 1/0", k, hazard1, hazard2);
            end
            cycle();
        end
        pipe_we = 1'b0;
        vectors++;
        if (hazard1 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL haz_prepop: got %b want 1", hazard1);
        end
        cycle();
        vectors++;
        if ({rf_we, rf_waddr} !== {1'b1, 5'd6} || hazard1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL haz_pop: got we=%b a=%0d h1=%b want 1/6 h1=0", rf_we, rf_waddr, hazard1);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        repeat (DEPTH + 2) cycle();
        raddr1 = 5'd11;
        raddr2 = 5'd12;
        for (int k = 0; k < 3; k++) begin
            pipe_we    = 1'b1;
            pipe_waddr = 5'd20;
            pipe_wdata = 32'h5;
            lu_valid   = 1'b1;
            lu_waddr   = 5'(11 + k);
            lu_wdata   = 32'hE0 + 32'(k);
            cycle();
        end
        lu_valid = 1'b0;
        rst      = 1'b1;
        #1;
        vectors++;
        if ({lu_ready, hazard1, hazard2} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rstmid_flags: got ready=%b h1=%b h2=%b want 000", lu_ready, hazard1, hazard2);
        end
        cycle();
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            miscompares++;
            $display("[TB] FAIL rstmid_rf: got we=%b a=%0d d=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        rst     = 1'b0;
        pipe_we = 1'b0;
        #1;
        vectors++;
        if ({lu_ready, hazard1, hazard2} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL rstmid_release: got ready=%b h1=%b h2=%b want 100", lu_ready, hazard1, hazard2);
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            vectors++;
            if (rf_we !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rstmid_stale %0d: got we=%b a=%0d want we=0", k, rf_we, rf_waddr);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            pipe_we    = ($urandom_range(0, 99) < 55);
            pipe_waddr = 5'($urandom_range(0, 7));
            pipe_wdata = $urandom;
            lu_valid   = ($urandom_range(0, 99) < 60);
            lu_waddr   = 5'($urandom_range(0, 7));
            lu_wdata   = $urandom;
            raddr1     = 5'($urandom_range(0, 7));
            raddr2     = 5'($urandom_range(0, 7));
            #1;
            vectors++;
            if ({lu_ready, hazard1, hazard2} !== {model_ready(), model_hazard(raddr1), model_hazard(raddr2)}) begin
                miscompares++;
                $display("[TB] FAIL rand_flags %0d: got ready=%b h1=%b h2=%b want %b %b %b", n,
                         lu_ready, hazard1, hazard2, model_ready(), model_hazard(raddr1), model_hazard(raddr2));
            end
            cycle();
            vectors++;
            if ({rf_we, rf_waddr, rf_wdata} !== {exp_we, exp_waddr, exp_wdata}) begin
                miscompares++;
                $display("[TB] FAIL rand_rf %0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h", n,
                         rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_fill_drain();
        test_priority();
        test_kill();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
        $fatal(1, "[TB] timeout");
    end

endmodule
